csr_timer_file: RTL and testbench

Parametrised LoongArch32 control/status register file with an integrated constant-frequency timer. It is the successor to the base CSR unit: it adds TID/TCFG/TVAL/TICLR, BADV, a configurable SAVE bank and masked writes for csrxchg. It sits beside EX (CSR read/write), feeds the exception entry to Pre-IF and the interrupt request to ID, and takes exception/ertn commits from WB.

---
 rtl/csr_timer_file_pkg.sv | 68 ++++++
 rtl/csr_timer_file_if.sv | 21 ++
 rtl/csr_timer_file_timer.sv | 54 +++++
 rtl/csr_timer_file.sv | 255 +++++++++++++++++++++++++
 tb/tb_csr_timer_file.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_timer_file_pkg.sv
// Shared definitions for the LoongArch32 CSR file with timer: CSR addresses,
// bitfield positions, exception codes and the masked-write merge helper.
package csr_pkg;

    typedef logic [13:0] csr_addr_t;

    // CSR addresses
    localparam csr_addr_t CSR_CRMD   = 14'h000;
    localparam csr_addr_t CSR_PRMD   = 14'h001;
    localparam csr_addr_t CSR_ECFG   = 14'h004;
    localparam csr_addr_t CSR_ESTAT  = 14'h005;
    localparam csr_addr_t CSR_ERA    = 14'h006;
    localparam csr_addr_t CSR_BADV   = 14'h007;
    localparam csr_addr_t CSR_EENTRY = 14'h00C;
    localparam csr_addr_t CSR_SAVE0  = 14'h030;
    localparam csr_addr_t CSR_TID    = 14'h040;
    localparam csr_addr_t CSR_TCFG   = 14'h041;
    localparam csr_addr_t CSR_TVAL   = 14'h042;
    localparam csr_addr_t CSR_TICLR  = 14'h044;

    // CRMD / PRMD fields
    localparam int CRMD_PLV_LSB = 0;
    localparam int CRMD_PLV_MSB = 1;
    localparam int CRMD_IE      = 2;
    localparam int CRMD_DA      = 3;
    localparam int CRMD_PG      = 4;
    localparam int PRMD_PPLV_LSB = 0;
    localparam int PRMD_PPLV_MSB = 1;
    localparam int PRMD_PIE      = 2;

    // ECFG / ESTAT fields
    localparam int ECFG_LIE_MSB       = 12;
    localparam logic [12:0] ECFG_LIE_WMASK = 13'h1BFF;
    localparam int ESTAT_IS_MSB       = 12;
    localparam int ESTAT_ECODE_LSB    = 16;
    localparam int ESTAT_ECODE_MSB    = 21;
    localparam int ESTAT_ESUB_LSB     = 22;
    localparam int ESTAT_ESUB_MSB     = 30;

    // TCFG fields and EENTRY alignment
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int EENTRY_VA_LSB    = 6;

    typedef enum logic [5:0] {
        ECODE_INT = 6'h00,
        ECODE_PIL = 6'h01,
        ECODE_PIS = 6'h02,
        ECODE_PIF = 6'h03,
        ECODE_PME = 6'h04,
        ECODE_PPI = 6'h07,
        ECODE_ADE = 6'h08,
        ECODE_ALE = 6'h09,
        ECODE_SYS = 6'h0B,
        ECODE_BRK = 6'h0C,
        ECODE_INE = 6'h0D,
        ECODE_IPE = 6'h0E
    } ecode_e;

    // csrxchg-style merge: masked bits come from wdata, the rest keep old
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] wmask);
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

endpackage

// File: rtl/csr_timer_file_if.sv
// CSR access bus between EX (master) and the CSR file (slave).
interface csr_timer_file_if;
    import csr_pkg::*;

    csr_addr_t   csr_num;
    logic        csr_re;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;

    modport master (
        output csr_num, csr_re, csr_we, csr_wmask, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_num, csr_re, csr_we, csr_wmask, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/csr_timer_file_timer.sv
// Constant-frequency timer: TCFG/TVAL registers, countdown with optional
// periodic reload, and a one-cycle pulse when the count expires.
module csr_timer
    import csr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_tcfg_we,
    input  logic [31:0] i_wval,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_timer_set
);

    localparam logic [TIMER_W-1:0] TVAL_ONES = '1;

    logic [TIMER_W-1:0] r_tcfg;
    logic [TIMER_W-1:0] r_tval;
    logic               w_en;
    logic               w_periodic;
    logic [TIMER_W-1:0] w_reload;

    assign w_en       = r_tcfg[TCFG_EN];
    assign w_periodic = r_tcfg[TCFG_PERIODIC];
    assign w_reload   = {r_tcfg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};

    // A TCFG write takes precedence over counting, so no expiry that cycle
    assign o_timer_set = w_en && !i_tcfg_we && (r_tval == '0);

    assign o_tcfg = 32'(r_tcfg);
    assign o_tval = 32'(r_tval);

    // Config load and countdown; a one-shot parks at all-ones after expiring
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge value of the others, independent of statement order.
        if (reset) begin
            r_tcfg <= '0;
            r_tval <= '0;
        end else if (i_tcfg_we) begin
            r_tcfg <= i_wval[TIMER_W-1:0];
            r_tval <= {i_wval[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
        end else if (w_en) begin
            if (r_tval == '0) begin
                r_tval <= w_periodic ? w_reload : TVAL_ONES;
            end else if (!(r_tval == TVAL_ONES && !w_periodic)) begin
                r_tval <= r_tval - 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_timer_file.sv
// LoongArch32 CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVEn/TID plus
// the timer CSRs. Combinational reads, masked writes, exception and ertn
// commits from WB, exception entry and interrupt request outputs.
module csr_timer_file
    import csr_pkg::*;
#(
    parameter int          TIMER_W  = 32,
    parameter int          SAVE_NUM = 4,
    parameter logic [31:0] COREID   = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    csr_timer_file_if.slave   csr_bus,
    input  logic [7:0]        hw_int_in,
    input  logic              ipi_int_in,
    output logic [31:0]       ex_entry,
    output logic              has_int,
    input  logic              ertn_flush,
    input  logic              wb_ex,
    input  logic [5:0]        wb_ecode,
    input  logic [8:0]        wb_esubcode,
    input  logic [31:0]       wb_pc,
    input  logic              wb_badv_we,
    input  logic [31:0]       wb_vaddr
);

    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ipi;
    logic        r_is_timer;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [25:0] r_eentry;
    logic [31:0] r_save [SAVE_NUM];
    logic [31:0] r_tid;

    logic [12:0] w_is;
    logic        w_save_hit;
    logic [31:0] w_reg_val;
    logic [31:0] w_wval;
    logic [31:0] w_tcfg_rd;
    logic [31:0] w_tval_rd;
    logic        w_timer_set;
    logic        w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat, w_wr_era;
    logic        w_wr_badv, w_wr_eentry, w_wr_tid, w_wr_tcfg, w_wr_ticlr;

    // IS[10] is reserved and always reads 0
    assign w_is = {r_is_ipi, r_is_timer, 1'b0, r_is_hw, r_is_sw};

    assign w_save_hit = (csr_bus.csr_num[13:4] == CSR_SAVE0[13:4]) &&
                        ({1'b0, csr_bus.csr_num[3:0]} < 5'(SAVE_NUM));

    // Register read mux; unimplemented addresses fall through to zero
    always_comb begin
        // NOTE: default first so every path assigns w_reg_val and no latch
        // is inferred for the addresses the case does not list.
        w_reg_val = '0;
        case (csr_bus.csr_num)
            CSR_CRMD: begin
                w_reg_val[CRMD_PLV_MSB:CRMD_PLV_LSB] = r_crmd_plv;
                w_reg_val[CRMD_IE] = r_crmd_ie;
                w_reg_val[CRMD_DA] = 1'b1;
                w_reg_val[CRMD_PG] = 1'b0;
            end
            CSR_PRMD: begin
                w_reg_val[PRMD_PPLV_MSB:PRMD_PPLV_LSB] = r_prmd_pplv;
                w_reg_val[PRMD_PIE] = r_prmd_pie;
            end
            CSR_ECFG:   w_reg_val[ECFG_LIE_MSB:0] = r_ecfg_lie;
            CSR_ESTAT: begin
                w_reg_val[ESTAT_IS_MSB:0] = w_is;
                w_reg_val[ESTAT_ECODE_MSB:ESTAT_ECODE_LSB] = r_ecode;
                w_reg_val[ESTAT_ESUB_MSB:ESTAT_ESUB_LSB] = r_esubcode;
            end
            CSR_ERA:    w_reg_val = r_era;
            CSR_BADV:   w_reg_val = r_badv;
            CSR_EENTRY: w_reg_val[31:EENTRY_VA_LSB] = r_eentry;
            CSR_TID:    w_reg_val = r_tid;
            CSR_TCFG:   w_reg_val = w_tcfg_rd;
            CSR_TVAL:   w_reg_val = w_tval_rd;
            default: begin
                for (int i = 0; i < SAVE_NUM; i++) begin
                    if (w_save_hit && csr_bus.csr_num[3:0] == 4'(i)) begin
                        w_reg_val = r_save[i];
                    end
                end
            end
        endcase
    end

    assign csr_bus.csr_rdata = csr_bus.csr_re ? w_reg_val : '0;
    assign w_wval = csr_merge(w_reg_val, csr_bus.csr_wdata, csr_bus.csr_wmask);

    assign w_wr_crmd   = csr_bus.csr_we && (csr_bus.csr_num == CSR_CRMD);
    assign w_wr_prmd   = csr_bus.csr_we && (csr_bus.csr_num == CSR_PRMD);
    assign w_wr_ecfg   = csr_bus.csr_we && (csr_bus.csr_num == CSR_ECFG);
    assign w_wr_estat  = csr_bus.csr_we && (csr_bus.csr_num == CSR_ESTAT);
    assign w_wr_era    = csr_bus.csr_we && (csr_bus.csr_num == CSR_ERA);
    assign w_wr_badv   = csr_bus.csr_we && (csr_bus.csr_num == CSR_BADV);
    assign w_wr_eentry = csr_bus.csr_we && (csr_bus.csr_num == CSR_EENTRY);
    assign w_wr_tid    = csr_bus.csr_we && (csr_bus.csr_num == CSR_TID);
    assign w_wr_tcfg   = csr_bus.csr_we && (csr_bus.csr_num == CSR_TCFG);
    assign w_wr_ticlr  = csr_bus.csr_we && (csr_bus.csr_num == CSR_TICLR);

    csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_tcfg_we   (w_wr_tcfg),
        .i_wval      (w_wval),
        .o_tcfg      (w_tcfg_rd),
        .o_tval      (w_tval_rd),
        .o_timer_set (w_timer_set)
    );

    // CRMD: exception drops to kernel with interrupts off, ertn restores
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd_plv <= 2'b00;
            r_crmd_ie  <= 1'b0;
        end else if (wb_ex) begin
            r_crmd_plv <= 2'b00;
            r_crmd_ie  <= 1'b0;
        end else if (ertn_flush) begin
            r_crmd_plv <= r_prmd_pplv;
            r_crmd_ie  <= r_prmd_pie;
        end else if (w_wr_crmd) begin
            r_crmd_plv <= w_wval[CRMD_PLV_MSB:CRMD_PLV_LSB];
            r_crmd_ie  <= w_wval[CRMD_IE];
        end
    end

    // PRMD: snapshot of CRMD privilege/IE on exception entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prmd_pplv <= 2'b00;
            r_prmd_pie  <= 1'b0;
        end else if (wb_ex) begin
            r_prmd_pplv <= r_crmd_plv;
            r_prmd_pie  <= r_crmd_ie;
        end else if (w_wr_prmd) begin
            r_prmd_pplv <= w_wval[PRMD_PPLV_MSB:PRMD_PPLV_LSB];
            r_prmd_pie  <= w_wval[PRMD_PIE];
        end
    end

    // ECFG: local interrupt enables, bit 10 is not writable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ecfg_lie <= '0;
        end else if (w_wr_ecfg) begin
            r_ecfg_lie <= (r_ecfg_lie & ~ECFG_LIE_WMASK) |
                          (w_wval[ECFG_LIE_MSB:0] & ECFG_LIE_WMASK);
        end
    end

    // ESTAT: exception cause on commit, software IS bits otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_sw    <= 2'b00;
            r_ecode    <= '0;
            r_esubcode <= '0;
        end else if (wb_ex) begin
            r_ecode    <= wb_ecode;
            r_esubcode <= wb_esubcode;
        end else if (w_wr_estat) begin
            r_is_sw    <= w_wval[1:0];
        end
    end

    // ESTAT: external interrupt lines sampled every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_hw  <= '0;
            r_is_ipi <= 1'b0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
        end
    end

    // ESTAT.IS[11]: timer expiry sets, TICLR clears, expiry wins a tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_timer <= 1'b0;
        end else if (w_timer_set) begin
            r_is_timer <= 1'b1;
        end else if (w_wr_ticlr && w_wval[0]) begin
            r_is_timer <= 1'b0;
        end
    end

    // ERA / BADV: faulting PC and address captured on exception commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_era  <= '0;
            r_badv <= '0;
        end else begin
            if (wb_ex) begin
                r_era <= wb_pc;
            end else if (w_wr_era) begin
                r_era <= w_wval;
            end
            if (wb_ex && wb_badv_we) begin
                r_badv <= wb_vaddr;
            end else if (w_wr_badv) begin
                r_badv <= w_wval;
            end
        end
    end

    // EENTRY (64-byte aligned) and TID
    always_ff @(posedge clk) begin
        if (reset) begin
            r_eentry <= '0;
            r_tid    <= COREID;
        end else begin
            if (w_wr_eentry) begin
                r_eentry <= w_wval[31:EENTRY_VA_LSB];
            end
            if (w_wr_tid) begin
                r_tid <= w_wval;
            end
        end
    end

    // SAVE bank: plain scratch registers for the exception handler
    always_ff @(posedge clk) begin
        // NOTE: the small SAVE bank is a register array, so it is reset like
        // any other flop; a large RAM-mapped bank would be left unreset.
        if (reset) begin
            for (int i = 0; i < SAVE_NUM; i++) begin
                r_save[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SAVE_NUM; i++) begin
                if (csr_bus.csr_we && w_save_hit && csr_bus.csr_num[3:0] == 4'(i)) begin
                    r_save[i] <= w_wval;
                end
            end
        end
    end

    assign ex_entry = {r_eentry, 6'b000000};
    assign has_int  = (|(w_is & r_ecfg_lie)) & r_crmd_ie;

endmodule

// File: tb/tb_csr_timer_file.sv
// Directed bench for csr_timer_file. The driver pushes hand-computed
// expectations into a scoreboard queue as it issues each read or probe; a
// monitor on the falling edge pops and compares whenever one is presented.
module tb_csr_timer_file;
    import csr_pkg::*;

    localparam logic [31:0] TB_COREID = 32'h0000_0005;
    localparam logic [31:0] ONES      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {K_RD, K_INT, K_ENT} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic        has_int;
    logic        ertn_flush;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        wb_badv_we;
    logic [31:0] wb_vaddr;
    logic        probe_int;
    logic        probe_ent;

    exp_t sb_q[$];
    exp_t mon_t;
    int   n_cmp;
    int   n_bad;

    csr_timer_file_if u_bus ();

    csr_timer_file #(
        .TIMER_W  (32),
        .SAVE_NUM (4),
        .COREID   (TB_COREID)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .csr_bus     (u_bus),
        .hw_int_in   (hw_int_in),
        .ipi_int_in  (ipi_int_in),
        .ex_entry    (ex_entry),
        .has_int     (has_int),
        .ertn_flush  (ertn_flush),
        .wb_ex       (wb_ex),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_pc       (wb_pc),
        .wb_badv_we  (wb_badv_we),
        .wb_vaddr    (wb_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input kind_e k, input string n, input logic [31:0] e);
        exp_t t;
        t.kind = k;
        t.name = n;
        t.exp  = e;
        sb_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e, input string n);
        u_bus.csr_num = a;
        u_bus.csr_re  = 1'b1;
        push_exp(K_RD, n, e);
        tick();
        u_bus.csr_re  = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        u_bus.csr_num   = a;
        u_bus.csr_we    = 1'b1;
        u_bus.csr_wdata = d;
        u_bus.csr_wmask = m;
        tick();
        u_bus.csr_we    = 1'b0;
    endtask

    task automatic expect_int(input logic e, input string n);
        probe_int = 1'b1;
        push_exp(K_INT, n, {31'b0, e});
        tick();
        probe_int = 1'b0;
    endtask

    task automatic expect_ent(input logic [31:0] e, input string n);
        probe_ent = 1'b1;
        push_exp(K_ENT, n, e);
        tick();
        probe_ent = 1'b0;
    endtask

    task automatic ex_commit(input logic [31:0] pc, input logic [31:0] va, input logic bwe,
                             input logic [5:0] ec, input logic [8:0] esc);
        wb_ex       = 1'b1;
        wb_pc       = pc;
        wb_vaddr    = va;
        wb_badv_we  = bwe;
        wb_ecode    = ec;
        wb_esubcode = esc;
        tick();
        wb_ex       = 1'b0;
        wb_badv_we  = 1'b0;
    endtask

    task automatic ertn();
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
    endtask

    // Monitor: compare whenever a read or probe is presented
    always @(negedge clk) begin
        if (u_bus.csr_re || probe_int || probe_ent) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                mon_t = sb_q.pop_front();
                case (mon_t.kind)
                    K_RD:    check(mon_t.name, u_bus.csr_rdata, mon_t.exp);
                    K_INT:   check(mon_t.name, {31'b0, has_int}, mon_t.exp);
                    default: check(mon_t.name, ex_entry, mon_t.exp);
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        hw_int_in = '0;
        ipi_int_in = 1'b0;
        ertn_flush = 1'b0;
        wb_ex = 1'b0;
        wb_ecode = '0;
        wb_esubcode = '0;
        wb_pc = '0;
        wb_badv_we = 1'b0;
        wb_vaddr = '0;
        probe_int = 1'b0;
        probe_ent = 1'b0;
        u_bus.csr_num = '0;
        u_bus.csr_re = 1'b0;
        u_bus.csr_we = 1'b0;
        u_bus.csr_wmask = '0;
        u_bus.csr_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        rd(CSR_CRMD,  32'h0000_0008, "rst_crmd");
        rd(CSR_PRMD,  32'h0,         "rst_prmd");
        rd(CSR_ECFG,  32'h0,         "rst_ecfg");
        rd(CSR_ESTAT, 32'h0,         "rst_estat");
        rd(CSR_TCFG,  32'h0,         "rst_tcfg");
        rd(CSR_TVAL,  32'h0,         "rst_tval");
        rd(CSR_TID,   TB_COREID,     "rst_tid");
        expect_int(1'b0,             "rst_has_int");
        expect_ent(32'h0,            "rst_ex_entry");

        // Masked write (csrxchg) and SAVE bank boundaries
        wr(CSR_SAVE0, 32'hFFFF_0000, ONES);
        wr(CSR_SAVE0, 32'h1234_5678, 32'h0000_FFFF);
        rd(CSR_SAVE0, 32'hFFFF_5678, "save0_xchg");
        wr(14'h033, 32'hA5A5_A5A5, ONES);
        rd(14'h033, 32'hA5A5_A5A5, "save3_last");
        wr(14'h034, 32'h1111_1111, ONES);
        rd(14'h034, 32'h0, "save4_unimpl");
        wr(14'h002, ONES, ONES);
        rd(14'h002, 32'h0, "unimpl_addr");
        wr(CSR_TVAL, 32'h0000_0055, ONES);
        rd(CSR_TVAL, 32'h0, "tval_ro");
        rd(CSR_TICLR, 32'h0, "ticlr_reads0");
        wr(CSR_TID, 32'h0000_CAFE, ONES);
        rd(CSR_TID, 32'h0000_CAFE, "tid_wr");

        // One-shot timer, k=2: TVAL 8..0, then IS[11] and TVAL parks at all-ones
        wr(CSR_TCFG, 32'h0000_0009, ONES);
        for (int i = 0; i < 9; i++) begin
            rd(CSR_TVAL, 32'(8 - i), $sformatf("oneshot_tval_%0d", 8 - i));
        end
        rd(CSR_ESTAT, 32'h0000_0800, "oneshot_is11");
        rd(CSR_TVAL, ONES, "oneshot_park");
        rd(CSR_TVAL, ONES, "oneshot_hold");
        rd(CSR_TCFG, 32'h0000_0009, "tcfg_readback");
        expect_int(1'b0, "has_int_lie_off");
        wr(CSR_ECFG, 32'h0000_0800, ONES);
        wr(CSR_CRMD, 32'h0000_0004, 32'h0000_0004);
        expect_int(1'b1, "has_int_timer");
        rd(CSR_CRMD, 32'h0000_000C, "crmd_ie_masked");
        wr(CSR_TICLR, 32'h1, ONES);
        expect_int(1'b0, "has_int_ticlr");
        rd(CSR_ESTAT, 32'h0, "estat_ticlr");
        wr(CSR_TCFG, 32'h0, ONES);
        rd(CSR_TVAL, 32'h0, "tval_disable");

        // Periodic timer, k=1: period 5; TICLR in the expiry cycle loses
        wr(CSR_TCFG, 32'h0000_0007, ONES);
        for (int i = 0; i < 4; i++) begin
            rd(CSR_TVAL, 32'(4 - i), $sformatf("per_tval_%0d", 4 - i));
        end
        rd(CSR_ESTAT, 32'h0, "per_is11_not_yet");
        rd(CSR_ESTAT, 32'h0000_0800, "per_is11_set");
        wr(CSR_TICLR, 32'h1, ONES);
        rd(CSR_ESTAT, 32'h0, "per_ticlr");
        rd(CSR_TVAL, 32'h1, "per_tval_1b");
        wr(CSR_TICLR, 32'h1, ONES);
        rd(CSR_ESTAT, 32'h0000_0800, "per_set_wins");
        rd(CSR_TVAL, 32'h3, "per_reloaded");
        wr(CSR_TCFG, 32'h0, ONES);
        wr(CSR_TICLR, 32'h1, ONES);
        rd(CSR_ESTAT, 32'h0, "per_stopped");

        // Exception entry with a concurrent unrelated CSR write
        wr(CSR_CRMD, ONES, ONES);
        rd(CSR_CRMD, 32'h0000_000F, "crmd_wmask");
        wr(CSR_ECFG, 32'h0, ONES);
        u_bus.csr_num = 14'h031;
        u_bus.csr_we = 1'b1;
        u_bus.csr_wdata = 32'h1111_2222;
        u_bus.csr_wmask = ONES;
        ex_commit(32'h1C00_0000, 32'h1C00_0003, 1'b1, 6'h09, 9'h0);
        u_bus.csr_we = 1'b0;
        rd(CSR_ERA,   32'h1C00_0000, "ex_era");
        rd(CSR_BADV,  32'h1C00_0003, "ex_badv");
        rd(CSR_PRMD,  32'h0000_0007, "ex_prmd");
        rd(CSR_CRMD,  32'h0000_0008, "ex_crmd");
        rd(CSR_ESTAT, 32'h0009_0000, "ex_estat");
        rd(14'h031,   32'h1111_2222, "ex_save1_concurrent");
        ertn();
        rd(CSR_CRMD, 32'h0000_000F, "ertn_crmd");
        rd(CSR_PRMD, 32'h0000_0007, "ertn_prmd");

        // Exception beats a same-cycle ERA write; BADV untouched without badv_we
        u_bus.csr_num = CSR_ERA;
        u_bus.csr_we = 1'b1;
        u_bus.csr_wdata = 32'hDEAD_BEEF;
        u_bus.csr_wmask = ONES;
        ex_commit(32'h2000_0000, ONES, 1'b0, 6'h08, 9'h001);
        u_bus.csr_we = 1'b0;
        rd(CSR_ERA,   32'h2000_0000, "ex2_era_wins");
        rd(CSR_BADV,  32'h1C00_0003, "ex2_badv_kept");
        rd(CSR_ESTAT, 32'h0048_0000, "ex2_estat");
        ertn();
        rd(CSR_CRMD, 32'h0000_000F, "ertn2_crmd");

        // Hardware and IPI interrupts, LIE bit 10 read-only
        hw_int_in = 8'h01;
        wr(CSR_ECFG, 32'h0000_0004, ONES);
        expect_int(1'b1, "has_int_hw");
        rd(CSR_ESTAT, 32'h0048_0004, "estat_hw");
        wr(CSR_ECFG, 32'h0000_0400, ONES);
        rd(CSR_ECFG, 32'h0, "ecfg_lie10_ro");
        expect_int(1'b0, "has_int_hw_masked");
        hw_int_in = 8'h00;
        ipi_int_in = 1'b1;
        wr(CSR_ECFG, 32'h0000_1000, ONES);
        expect_int(1'b1, "has_int_ipi");
        ipi_int_in = 1'b0;
        wr(CSR_ECFG, 32'h0, ONES);

        // Software IS bits and masked ESTAT write
        wr(CSR_ESTAT, ONES, ONES);
        rd(CSR_ESTAT, 32'h0048_0003, "estat_sw");
        wr(CSR_ESTAT, 32'h0, 32'h0000_0001);
        rd(CSR_ESTAT, 32'h0048_0002, "estat_sw_masked");

        // EENTRY alignment
        wr(CSR_EENTRY, ONES, ONES);
        rd(CSR_EENTRY, 32'hFFFF_FFC0, "eentry_rd");
        expect_ent(32'hFFFF_FFC0, "ex_entry_out");

        // Reset in the middle of a count
        wr(CSR_TCFG, 32'h0000_0101, ONES);
        rd(CSR_TVAL, 32'h0000_0100, "mid_tval_init");
        rd(CSR_TVAL, 32'h0000_00FF, "mid_tval_dec");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(CSR_TCFG,  32'h0,         "rst2_tcfg");
        rd(CSR_TVAL,  32'h0,         "rst2_tval");
        rd(CSR_ESTAT, 32'h0,         "rst2_estat");
        rd(CSR_CRMD,  32'h0000_0008, "rst2_crmd");
        rd(CSR_TID,   TB_COREID,     "rst2_tid");
        rd(CSR_EENTRY, 32'h0,        "rst2_eentry");

        tick();
        tick();
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
